// File: rtl/shift_sub_divider.sv
// Restoring shift-subtract divider: 32-bit unsigned A/B, one quotient bit per clock.
// A zero divisor completes at once, with quotient all-ones and remainder A.
module shift_sub_divider (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] A,
  input  logic [31:0] B,
  output logic [31:0] quotient,
  output logic [31:0] remainder,
  output logic        done,
  output logic        busy,
  output logic        div_zero
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t      state, state_nxt;
  logic [31:0] dvd;      // dividend shifts out MSB-first while quotient bits shift in
  logic [31:0] dvs;
  logic [31:0] rem;
  logic [4:0]  cnt;

  logic [32:0] trial, diff;
  logic        fits;
  logic [31:0] rem_nxt, dvd_nxt;
  logic        last;

  always_comb begin
    trial   = {rem, dvd[31]};
    diff    = trial - {1'b0, dvs};
    fits    = trial >= {1'b0, dvs};
    rem_nxt = fits ? diff[31:0] : trial[31:0];
    dvd_nxt = {dvd[30:0], fits};
    last    = (cnt == 5'd31);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = (B == 32'd0) ? DONE : CALC;
      CALC:    if (last)  state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dvd       <= '0;
      dvs       <= '0;
      rem       <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          if (B == 32'd0) begin
            quotient  <= '1;
            remainder <= A;
            div_zero  <= 1'b1;
          end else begin
            dvd <= A;
            dvs <= B;
            rem <= '0;
            cnt <= '0;
          end
        end
        CALC: begin
          dvd <= dvd_nxt;
          rem <= rem_nxt;
          cnt <= cnt + 5'd1;
          // Results only become visible on the final iteration.
          if (last) begin
            quotient  <= dvd_nxt;
            remainder <= rem_nxt;
            div_zero  <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

  assign done = (state == DONE);
  assign busy = (state == CALC);

endmodule

// File: tb/tb_shift_sub_divider.sv
// Self-checking bench for shift_sub_divider: cycle-level behavioural model plus
// directed literal cases and random operand pairs.
module tb_shift_sub_divider;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic [31:0] quotient, remainder;
  logic        done, busy, div_zero;

  int checks = 0;
  int errors = 0;

  shift_sub_divider dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .quotient(quotient), .remainder(remainder),
    .done(done), .busy(busy), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  // Behavioural model: a busy countdown and results from plain / and %.
  logic [31:0] m_q, m_r, pa, pb;
  logic        m_dz, m_done;
  int          m_left;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_q = 0; m_r = 0; m_dz = 0; m_done = 0; m_left = 0;
    end else if (m_done) begin
      m_done = 0;
    end else if (m_left > 0) begin
      m_left = m_left - 1;
      if (m_left == 0) begin
        m_q = pa / pb; m_r = pa % pb; m_dz = 0; m_done = 1;
      end
    end else if (start) begin
      if (B == 0) begin
        m_q = 32'hFFFF_FFFF; m_r = A; m_dz = 1; m_done = 1;
      end else begin
        pa = A; pb = B; m_left = 32;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("model_busy", 32'(busy), 32'(m_left > 0));
    chk("model_done", 32'(done), 32'(m_done));
    chk("model_dz", 32'(div_zero), 32'(m_dz));
    chk("model_q", quotient, m_q);
    chk("model_r", remainder, m_r);
  end

  // Waits at negedges for done; n = edges after the accept edge, nb = busy cycles.
  task automatic wait_done(output int n, output int nb);
    n = 0; nb = 0;
    while (!done && n < 100) begin
      if (busy) nb++;
      @(negedge clk);
      n++;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL wait_done: timeout after %0d cycles", n);
    end
  endtask

  // Starts at a negedge, finishes at the negedge after the DONE cycle.
  task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eq, input logic [31:0] er,
                       input logic edz, input int elat, input string name);
    int n, nb;
    A = a; B = b; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(n, nb);
    chk({name, "_q"}, quotient, eq);
    chk({name, "_r"}, remainder, er);
    chk({name, "_dz"}, 32'(div_zero), 32'(edz));
    chk({name, "_lat"}, n, elat);
    chk({name, "_busy"}, nb, (elat == 0) ? 0 : 32);
    @(negedge clk);
  endtask

  initial begin
    int n, nb, n2;
    logic [31:0] a, b;
    repeat (2) @(negedge clk);
    chk("rst_q", quotient, 0);
    chk("rst_r", remainder, 0);
    chk("rst_flags", {29'd0, done, busy, div_zero}, 0);
    rst = 1'b0;
    @(negedge clk);

    do_op(220, 22, 10, 0, 0, 32, "r026");
    do_op(3, 10, 0, 3, 0, 32, "a_lt_b");
    do_op(32'hFFFF_FFFF, 1, 32'hFFFF_FFFF, 0, 0, 32, "max_b1");
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, 0, 32, "max_max");
    do_op(0, 9, 0, 0, 0, 32, "a_zero");
    do_op(5, 0, 32'hFFFF_FFFF, 5, 1, 0, "div0");
    do_op(7, 3, 2, 1, 0, 32, "after_div0");

    // Start held high; operands wander during CALC.
    A = 100; B = 7; start = 1'b1;
    @(negedge clk);
    n = 0;
    while (!done && n < 100) begin
      A = $urandom; B = $urandom | 32'd1;
      @(negedge clk); n++;
    end
    chk("held_q", quotient, 14);
    chk("held_r", remainder, 2);
    chk("held_lat", n, 32);
    A = 50; B = 5;
    @(negedge clk);
    n2 = 0;
    while (!done && n2 < 100) begin
      @(negedge clk); n2++;
    end
    start = 1'b0;
    chk("held2_q", quotient, 10);
    chk("held2_r", remainder, 0);
    chk("held2_gap", n2, 33);
    @(negedge clk);

    // Reset mid-calculation, with start held through reset.
    A = 1000; B = 7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_q", quotient, 0);
    chk("midrst_r", remainder, 0);
    chk("midrst_flags", {29'd0, done, busy, div_zero}, 0);
    start = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_ignores_start", {31'd0, busy}, 0);
    rst = 1'b0;
    do_op(1000, 7, 142, 6, 0, 32, "post_rst");

    for (int i = 0; i < 1000; i++) begin
      a = $urandom;
      case (i % 4)
        0: b = $urandom_range(1, 15);
        1: b = $urandom | 32'd1;
        2: b = 32'($urandom_range(1, 65535));
        default: b = ($urandom >> $urandom_range(0, 31)) | 32'd1;
      endcase
      do_op(a, b, a / b, a % b, 0, 32, "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
